keypad_scanner: RTL

Upstream stage of key_decode. Drives the 4x4 matrix keypad rows, samples the columns through a synchronizer, and debounces presses and releases. Produces registered one-hot active-high row and column codes (r, c) that feed key_decode directly, plus a one-cycle new-key strobe. Exactly one key is accepted at a time; there is no auto-repeat.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/keypad_scanner_sync_2ff.sv | 26 ++
 rtl/keypad_scanner.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared sizes and FSM state encoding for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   // True when exactly one column is asserted; zero or several are rejected as ghosts.
   function automatic logic single_col(input logic [NUM_COLS-1:0] cols);
      return ($countones(cols) == 1);
   endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for the raw keypad columns; resets to all ones (released keys).
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column synchronizing, press/release debounce.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SCAN     | drive one row per dwell period, look for exactly one column
// DEBOUNCE | row frozen, candidate column must stay identical for the window
// HELD     | key accepted, wait for its column bit to drop
// RELEASE  | column bit low, must stay low for the window before rescanning
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 2400,
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_COLS-1:0] col_n,
   output logic [NUM_ROWS-1:0] row_drv_n,
   output logic [NUM_ROWS-1:0] r,
   output logic [NUM_COLS-1:0] c,
   output logic                key_valid,
   output logic                key_held
);

   localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [NUM_ROWS-1:0] TOP_ROW = {1'b1, {(NUM_ROWS-1){1'b0}}};

   logic [NUM_COLS-1:0] col_n_sync;
   logic [NUM_COLS-1:0] col_s;

   scan_state_t         state_q,     state_d;
   logic [1:0]          row_idx_q,   row_idx_d;
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic [NUM_COLS-1:0] lat_col_q,   lat_col_d;
   logic [NUM_ROWS-1:0] r_q,         r_d;
   logic [NUM_COLS-1:0] c_q,         c_d;
   logic                key_valid_q, key_valid_d;
   logic                key_held_q,  key_held_d;

   sync_2ff #(
      .WIDTH (NUM_COLS)
   ) u_col_sync (
      .clk   (clk),
      .rst_n (reset),
      .d     (col_n),
      .q     (col_n_sync)
   );

   assign col_s = ~col_n_sync;

   always_comb begin
      state_d     = state_q;
      row_idx_d   = row_idx_q;
      cnt_d       = cnt_q;
      lat_col_d   = lat_col_q;
      r_d         = r_q;
      c_d         = c_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;

      unique case (state_q)
         SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               if (single_col(col_s)) begin
                  lat_col_d = col_s;
                  state_d   = DEBOUNCE;
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         DEBOUNCE: begin
            if (col_s != lat_col_q) begin
               cnt_d     = '0;
               row_idx_d = row_idx_q + 2'd1;
               state_d   = SCAN;
            end else if (cnt_q == DEB_LAST) begin
               cnt_d       = '0;
               r_d         = TOP_ROW >> row_idx_q;
               c_d         = lat_col_q;
               key_valid_d = 1'b1;
               key_held_d  = 1'b1;
               state_d     = HELD;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         // Only the accepted column is watched; neighbours on this row are don't-care.
         HELD: begin
            if ((col_s & lat_col_q) == '0) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end
         end

         RELEASE: begin
            if ((col_s & lat_col_q) != '0) begin
               state_d = HELD;
            end else if (cnt_q == DEB_LAST) begin
               cnt_d      = '0;
               key_held_d = 1'b0;
               row_idx_d  = row_idx_q + 2'd1;
               state_d    = SCAN;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = SCAN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         row_idx_q   <= 2'd0;
         cnt_q       <= '0;
         lat_col_q   <= '0;
         r_q         <= '0;
         c_q         <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_idx_q   <= row_idx_d;
         cnt_q       <= cnt_d;
         lat_col_q   <= lat_col_d;
         r_q         <= r_d;
         c_q         <= c_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   // Row drive decodes straight from the index flop so reset forces row 0 immediately.
   assign row_drv_n = ~(TOP_ROW >> row_idx_q);
   assign r         = r_q;
   assign c         = c_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule
